// File: rtl/audio_codec_pkg.sv
// Shared constants and types for the PAPU codec serial link.
package audio_codec_pkg;
  localparam int SAMPLE_W        = 16;
  localparam int SLOT_W          = 32;
  localparam int FRAME_BITS      = 64;
  localparam int CNT_W           = 6;
  localparam int DEFAULT_CLK_DIV = 4;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [CNT_W-1:0]    bit_cnt_t;
endpackage

// File: rtl/codec_bclk_gen.sv
// Bit-clock divider, rise/fall strobes, frame bit counter and LR clock.
module codec_bclk_gen
  import audio_codec_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic     clk,
  input  logic     rst_n,
  output logic     bclk,
  output logic     rise,
  output logic     fall,
  output bit_cnt_t bit_cnt,
  output logic     lrck
);
  localparam int DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;
  bit_cnt_t         bit_nxt;

  // Strobes mark the clk edge on which BCLK toggles, not the cycle after.
  assign wrap    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise    = wrap & ~bclk;
  assign fall    = wrap & bclk;
  assign bit_nxt = bit_cnt + 1'b1;

  // bit_cnt parks at 63 so the first fall opens frame bit 0; LRCK is its own
  // register because it must read 0 during reset while bit_cnt[5] is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '1;
      lrck    <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) bclk <= ~bclk;
      if (fall) begin
        bit_cnt <= bit_nxt;
        lrck    <= bit_nxt[CNT_W-1];
      end
    end
  end
endmodule

// File: rtl/audio_codec_link.sv
// Left-justified stereo codec link: DAC serializer, sample request, ADC capture.
// Optional ADC capture path enabled by defining AUDIO_CODEC_ADC_EN.
module audio_codec_link
  import audio_codec_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                sample_req,
  input  logic [SAMPLE_W-1:0] dac_data,
  output logic                sample_end,
  output logic [SAMPLE_W-1:0] adc_data,
  output logic                AUD_BCLK,
  output logic                AUD_DACLRCK,
  output logic                AUD_DACDAT,
  output logic                AUD_ADCLRCK,
  input  logic                AUD_ADCDAT
);
  logic     rise, fall;
  bit_cnt_t bit_cnt, bit_nxt;
  sample_t  tx_hold, tx_word;
  logic [3:0] k;

  codec_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .bclk   (AUD_BCLK),
    .rise   (rise),
    .fall   (fall),
    .bit_cnt(bit_cnt),
    .lrck   (AUD_DACLRCK)
  );

  assign AUD_ADCLRCK = AUD_DACLRCK;
  assign bit_nxt     = bit_cnt + 1'b1;
  assign k           = bit_nxt[3:0];
  // Bit 0 goes out on the latch edge itself, so bypass the hold register then.
  assign tx_word     = (bit_nxt == '0) ? dac_data : tx_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold    <= '0;
      AUD_DACDAT <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      sample_req <= fall && (bit_nxt == '1);
      if (fall) begin
        if (bit_nxt == '0) tx_hold <= dac_data;
        // ~k == 15-k: MSB first in the upper 16 bits of each slot, then zeros.
        AUD_DACDAT <= bit_nxt[4] ? 1'b0 : tx_word[~k];
      end
    end
  end

`ifdef AUDIO_CODEC_ADC_EN
  sample_t rx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift   <= '0;
      adc_data   <= '0;
      sample_end <= 1'b0;
    end else begin
      sample_end <= 1'b0;
      if (rise && (bit_cnt[5:4] == 2'b00)) begin
        rx_shift <= {rx_shift[SAMPLE_W-2:0], AUD_ADCDAT};
        if (bit_cnt[3:0] == 4'hF) begin
          adc_data   <= {rx_shift[SAMPLE_W-2:0], AUD_ADCDAT};
          sample_end <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_adc;
  assign unused_adc = ^{AUD_ADCDAT, rise};
  assign adc_data   = '0;
  assign sample_end = 1'b0;
`endif
endmodule
